// File: rtl/rect_pkg.sv
// Shared constants and state encoding for the rectangle-fill sequencer.
package rect_pkg;

  localparam int RECT_X_W      = 9;
  localparam int RECT_Y_W      = 8;
  localparam int RECT_COLOR_W  = 3;
  localparam int RECT_SCREEN_W = 320;
  localparam int RECT_SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sweep_counter.sv
// Row-major 2-D column/row counter for one rectangle; clear restarts at (0,0),
// en advances one pixel, last flags the final pixel of a w x h sweep.
module sweep_counter
  import rect_pkg::*;
#(
  parameter int X_W = RECT_X_W,
  parameter int Y_W = RECT_Y_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           last
);

  localparam logic [X_W-1:0] ONE_X = 1;
  localparam logic [Y_W-1:0] ONE_Y = 1;

  logic col_end;

  assign col_end = (col == w - ONE_X);
  assign last    = col_end && (row == h - ONE_Y);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row + ONE_Y;
      end else begin
        col <= col + ONE_X;
      end
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle-fill sequencer: accepts one rectangle per handshake and emits one
// registered plot strobe per unstalled cycle. Optional clipping: RECT_PLOTTER_CLIP_EN.
//
// state | meaning
// IDLE  | waiting for a request (req_ready follows one cycle behind)
// SWEEP | counter walking the rectangle; outputs trail the counter by one cycle
// DONE  | last pixel on the outputs (held while stalled); done pulses next cycle
module rect_plotter
  import rect_pkg::*;
#(
  parameter int X_W      = RECT_X_W,
  parameter int Y_W      = RECT_Y_W,
  parameter int COLOR_W  = RECT_COLOR_W,
  parameter int SCREEN_W = RECT_SCREEN_W,
  parameter int SCREEN_H = RECT_SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x,
  input  logic [Y_W-1:0]     req_y,
  input  logic [X_W-1:0]     req_w,
  input  logic [Y_W-1:0]     req_h,
  input  logic [COLOR_W-1:0] req_color,
  input  logic               stall,
  output logic               plot,
  output logic [X_W-1:0]     plot_x,
  output logic [Y_W-1:0]     plot_y,
  output logic [COLOR_W-1:0] plot_color,
  output logic               busy,
  output logic               done
);

  if (SCREEN_W > (1 << X_W) || SCREEN_H > (1 << Y_W)) begin : g_screen_chk
    $error("rect_plotter: screen size does not fit the coordinate widths");
  end

  state_t state, state_nx;

  logic [X_W-1:0]     x_q, w_q;
  logic [Y_W-1:0]     y_q, h_q;
  logic [COLOR_W-1:0] color_q;

  logic           accept;
  logic           count_en;
  logic           hold_last;
  logic           last;
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  logic           vis;

  assign accept    = req_valid && req_ready && (state == IDLE);
  assign count_en  = (state == SWEEP) && !stall;
  // The final pixel is on the outputs during DONE; a stall must keep it there.
  assign hold_last = (state == DONE) && plot && stall;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (req_w == '0 || req_h == '0) ? DONE : SWEEP;
      SWEEP:   if (count_en && last) state_nx = DONE;
      DONE:    if (!hold_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (accept) begin
      x_q     <= req_x;
      y_q     <= req_y;
      w_q     <= req_w;
      h_q     <= req_h;
      color_q <= req_color;
    end
  end

  sweep_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_sweep_counter (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (count_en),
    .w     (w_q),
    .h     (h_q),
    .col   (col),
    .row   (row),
    .last  (last)
  );

`ifdef RECT_PLOTTER_CLIP_EN
  localparam logic [X_W:0] SCR_W = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] SCR_H = SCREEN_H[Y_W:0];

  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;

  assign sum_x = {1'b0, x_q} + {1'b0, col};
  assign sum_y = {1'b0, y_q} + {1'b0, row};
  assign vis   = (sum_x < SCR_W) && (sum_y < SCR_H);
`else
  // Without clipping only the wrapped low bits of the sums are ever visible.
  logic [X_W-1:0] sum_x;
  logic [Y_W-1:0] sum_y;

  assign sum_x = x_q + col;
  assign sum_y = y_q + row;
  assign vis   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      plot       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_color <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      req_ready <= (state == IDLE) && !accept;
      busy      <= (state == SWEEP) || hold_last;
      done      <= (state == DONE) && !hold_last;
      if (count_en) begin
        plot       <= vis;
        plot_x     <= sum_x[X_W-1:0];
        plot_y     <= sum_y[Y_W-1:0];
        plot_color <= color_q;
      end else if (!((state == SWEEP) || hold_last)) begin
        plot <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed and random rectangles checked
// cycle by cycle against a per-pixel timeline model.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       stall = 1'b0;
  logic [8:0] req_x = '0;
  logic [7:0] req_y = '0;
  logic [8:0] req_w = '0;
  logic [7:0] req_h = '0;
  logic [2:0] req_color = '0;
  logic       req_ready, plot, busy, done;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [2:0] plot_color;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rect_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_color  (req_color),
    .stall      (stall),
    .plot       (plot),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_color (plot_color),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_req();
    req_x     = 9'($urandom);
    req_y     = 8'($urandom);
    req_w     = 9'($urandom);
    req_h     = 8'($urandom);
    req_color = 3'($urandom);
  endtask

  // Timeline phases: 0 nothing shown yet, 1 pixel idx shown, 2 done pulse,
  // 3 ready again, 4 zero-size rectangle just accepted.
  task automatic run_rect(input int x, input int y, input int w, input int h, input int c,
                          input logic [63:0] mask, input bit noise, input int abort_k);
    int  ph, idx, n, k, wait_cnt, cx, ry, ex, ey;
    bit  vis, finished;
    logic st;
    n = w * h;
    wait_cnt = 0;
    while (req_ready !== 1'b1 && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("ready_before_req", req_ready, 1);
    req_x = 9'(x); req_y = 8'(y); req_w = 9'(w); req_h = 8'(h); req_color = 3'(c);
    req_valid = 1'b1;
    @(posedge clk); #1;
    check("ready_after_accept", req_ready, 0);
    if (noise) scramble_req();
    else req_valid = 1'b0;
    st = mask[0];
    stall = st;
    ph = (n == 0) ? 4 : 0;
    idx = 0;
    finished = 0;
    k = 1;
    while (!finished && k < 400) begin
      @(posedge clk); #1;
      case (ph)
        4: ph = 2;
        0: if (!st) begin ph = 1; idx = 0; end
        1: if (!st) begin
             if (idx == n - 1) ph = 2;
             else idx++;
           end
        2: ph = 3;
        default: ;
      endcase
      cx = (w > 0) ? idx % w : 0;
      ry = (w > 0) ? idx / w : 0;
      ex = (x + cx) % 512;
      ey = (y + ry) % 256;
`ifdef RECT_PLOTTER_CLIP_EN
      vis = (x + cx < 320) && (y + ry < 240);
`else
      vis = 1'b1;
`endif
      check("plot",      plot,      (ph == 1 && vis) ? 1 : 0);
      check("busy",      busy,      (ph == 0 || ph == 1) ? 1 : 0);
      check("done",      done,      (ph == 2) ? 1 : 0);
      check("req_ready", req_ready, (ph == 3) ? 1 : 0);
      if (ph == 1 && vis) begin
        check("plot_x",     plot_x,     ex);
        check("plot_y",     plot_y,     ey);
        check("plot_color", plot_color, c);
      end
      if (ph == 3) begin
        req_valid = 1'b0;
        stall = 1'b0;
        finished = 1;
      end else if (k == abort_k) begin
        stall = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_plot",  plot,      0);
        check("abort_busy",  busy,      0);
        check("abort_done",  done,      0);
        check("abort_ready", req_ready, 1);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          check("abort_no_done", done, 0);
          check("abort_idle_plot", plot, 0);
        end
        finished = 1;
      end else begin
        st = (k < 64) ? mask[k] : 1'b0;
        stall = st;
        if (noise) scramble_req();
      end
      k++;
    end
    if (!finished) check("rect_timeout", 0, 1);
  endtask

  initial begin
    int w, h;
    logic [63:0] m;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot",       plot,       0);
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_req_ready",  req_ready,  1);
    check("rst_plot_x",     plot_x,     0);
    check("rst_plot_y",     plot_y,     0);
    check("rst_plot_color", plot_color, 0);
    reset = 1'b0;

    run_rect(10, 20, 3, 2, 5, 64'h0, 0, 0);
    run_rect(30, 40, 0, 7, 2, 64'h0, 0, 0);
    run_rect(50, 60, 6, 0, 1, 64'h0, 0, 0);
    run_rect(0, 0, 4, 1, 1, 64'h1C, 0, 0);
    run_rect(318, 239, 4, 2, 6, 64'h0, 0, 0);
    run_rect(500, 250, 20, 10, 3, 64'h0, 0, 0);
    run_rect(0, 0, 10, 10, 7, 64'h0, 0, 15);
    run_rect(100, 100, 3, 3, 2, 64'h0, 0, 0);
    run_rect(5, 6, 2, 3, 4, 64'h0, 1, 0);
    run_rect(7, 8, 1, 1, 3, 64'h3, 0, 0);

    for (int i = 0; i < 14; i++) begin
      w = $urandom_range(0, 8);
      h = $urandom_range(0, 6);
      m = {$urandom, $urandom} & {$urandom, $urandom};
      run_rect($urandom_range(0, 320 - w), $urandom_range(0, 240 - h), w, h,
               $urandom_range(0, 7), m, 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
